// File: rtl/perm_pkg.sv
// perm_pkg: shared defaults and FSM state type for the permutation stream master.
package perm_pkg;
    localparam int WIDTH_DEF = 25;
    localparam int ROWS_DEF  = 64;
    localparam int AW        = 6;
    typedef enum logic [1:0] {IDLE, START, STREAM, FINISH} state_t;
endpackage

// File: rtl/perm_stream_master_if.sv
// perm_stream_master_if: handshake between the stream master and the permutation core.
interface perm_stream_master_if #(parameter int WIDTH = perm_pkg::WIDTH_DEF);
    logic             core_start;
    logic [WIDTH-1:0] core_in;
    logic             core_ready;
    logic             core_co;
    logic [WIDTH-1:0] core_out;
    modport master (output core_start, core_in, input core_ready, core_co, core_out);
    modport slave  (input core_start, core_in, output core_ready, core_co, core_out);
endinterface

// File: rtl/perm_row_buffer.sv
// perm_row_buffer: ROWS x WIDTH row store, one write port, one registered read port.
module perm_row_buffer import perm_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ROWS  = ROWS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);
    logic [WIDTH-1:0] mem [ROWS];
    // storage is intentionally left out of reset
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    always_ff @(posedge clk or negedge rst)
        if (!rst) rd <= '0;
        else      rd <= mem[ra];
endmodule

// File: rtl/perm_stream_master.sv
// perm_stream_master: streams source rows through a permutation core into a result buffer.
// Optional stall watchdog enabled by defining PERM_STREAM_TIMEOUT_EN.
module perm_stream_master import perm_pkg::*; #(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int START_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic [6:0]       row_count,
    output logic             err,
    perm_stream_master_if.master core
);
    localparam int SCW = START_CYCLES > 1 ? $clog2(START_CYCLES) : 1;
    state_t           state_q, state_d;
    logic [6:0]       idx, idx_d;
    logic [SCW-1:0]   sc;
    logic [WIDTH-1:0] src_q;
    logic             accept, last, stop, to_hit;
    assign accept          = state_q == STREAM && core.core_ready;
    assign last            = idx == 7'(ROWS - 1);
    assign stop            = accept && (core.core_co || last);
    assign busy            = state_q != IDLE;
    assign done            = state_q == FINISH;
    assign core.core_start = state_q == START;
    assign core.core_in    = src_q;
    // source is addressed with the next index so its registered output tracks idx
    perm_row_buffer #(.WIDTH(WIDTH), .ROWS(ROWS)) u_src (
        .clk(clk), .rst(rst), .we(wr_en && !busy), .wa(wr_addr), .wd(wr_data),
        .ra(idx_d[AW-1:0]), .rd(src_q)
    );
    perm_row_buffer #(.WIDTH(WIDTH), .ROWS(ROWS)) u_res (
        .clk(clk), .rst(rst), .we(accept), .wa(idx[AW-1:0]), .wd(core.core_out),
        .ra(rd_addr), .rd(rd_data)
    );
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = go ? START : IDLE;
            START:   state_d = sc == SCW'(START_CYCLES - 1) ? STREAM : START;
            STREAM:  state_d = (stop || to_hit) ? FINISH : STREAM;
            FINISH:  state_d = IDLE;
        endcase
        idx_d = state_q == START ? 7'd0 : (accept && !stop) ? idx + 7'd1 : idx;
    end
`ifdef PERM_STREAM_TIMEOUT_EN
    logic [9:0] wd;
    logic       to_q;
    assign to_hit = state_q == STREAM && !core.core_ready && &wd;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wd   <= '0;
            to_q <= 1'b0;
        end else begin
            wd   <= (state_q == STREAM && !core.core_ready) ? wd + 10'd1 : '0;
            to_q <= to_hit;
        end
`else
    assign to_hit = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            idx       <= '0;
            sc        <= '0;
            err       <= 1'b0;
            row_count <= '0;
        end else begin
            idx <= idx_d;
            sc  <= state_q == START ? sc + SCW'(1) : '0;
            err <= (state_q == IDLE && go) ? 1'b0 :
                   ((accept && last && !core.core_co) || to_hit) ? 1'b1 : err;
`ifdef PERM_STREAM_TIMEOUT_EN
            if (done) row_count <= to_q ? idx : idx + 7'd1;
`else
            if (done) row_count <= idx + 7'd1;
`endif
        end
endmodule

// File: tb/tb_perm_stream_master.sv
// tb_perm_stream_master: table-driven and randomized runs against a row-array model of the stream master.
module tb_perm_stream_master;
    logic        clk = 0, rst = 0, wr_en = 0, go = 0;
    logic [5:0]  wr_addr = 0, rd_addr = 0;
    logic [24:0] wr_data = 0, rd_data;
    logic        busy, done, err;
    logic [6:0]  row_count;
    int          errors = 0, checks = 0;
    logic [24:0] src [64];
    logic [24:0] res [64];

    perm_stream_master_if #(.WIDTH(25)) core();

    perm_stream_master dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .go(go), .busy(busy), .done(done),
        .row_count(row_count), .err(err), .core(core)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] perm(input logic [24:0] x);
        return {x[11:0], x[24:12]} ^ 25'h0A5A5A5;
    endfunction

    assign core.core_out = perm(core.core_in);

    typedef struct { int co_row; int per; int rows; bit err; bit reload; } vec_t;
    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wr_row(input int a, input logic [24:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = 6'(a); wr_data = d; src[a] = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic load(input bit rnd);
        for (int k = 0; k < 64; k++) wr_row(k, rnd ? 25'($urandom) : 25'(k));
    endtask

    task automatic rd_all();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk); rd_addr = 6'(k);
            @(negedge clk); chk("rd_data", rd_data, res[k]);
        end
    endtask

    task automatic finish_chk(input int rows, input bit e);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("row_count", row_count, rows);
        chk("err", err, e);
    endtask

    task automatic run(input int co_row, input int per, input int stall_after,
                       input int abort_row, input int max_cyc, output bit fin);
        int k = 0, cyc = 0, starts = 0;
        fin = 0;
        @(negedge clk); go = 1;
        @(negedge clk); go = 0;
        chk("err_cleared_by_go", err, 0);
        chk("busy_in_start", busy, 1);
        wr_en = 1; wr_addr = 0; wr_data = 25'h1FFFFFF;
        while (!fin && cyc < max_cyc) begin
            if (core.core_start) begin
                starts++;
                core.core_ready = 0; core.core_co = 0;
            end else if (done) fin = 1;
            else if (busy) begin
                if (k == abort_row) begin
                    rst = 0; #1;
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    chk("abort_core_start", core.core_start, 0);
                    go = 0; core.core_ready = 0; core.core_co = 0;
                    return;
                end
                chk("core_in", core.core_in, src[k]);
                go = (k == 3);
                core.core_ready = (cyc % per == 0) && k < stall_after;
                core.core_co = core.core_ready && k == co_row;
                if (core.core_ready) begin
                    res[k] = perm(src[k]);
                    k++;
                end
            end
            cyc++;
            if (!fin) begin
                @(negedge clk);
                wr_en = 0;
            end
        end
        go = 0; core.core_ready = 0; core.core_co = 0;
        if (fin) chk("start_cycles", starts, 2);
    endtask

    initial begin
        bit fin;
        int co, per;
        core.core_ready = 0; core.core_co = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_core_start", core.core_start, 0);
        chk("rst_err", err, 0);
        chk("rst_row_count", row_count, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1;
        load(0);
        vecs = '{'{63, 1, 64, 0, 0}, '{63, 3, 64, 0, 0}, '{9, 1, 10, 0, 1}, '{99, 1, 64, 1, 0},
                 '{0, 2, 1, 0, 1}, '{62, 4, 63, 0, 0}, '{99, 3, 64, 1, 1}};
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].reload) load(1);
            run(vecs[i].co_row, vecs[i].per, 99, -1, 1500, fin);
            chk("finished", fin, 1);
            if (fin) finish_chk(vecs[i].rows, vecs[i].err);
            rd_all();
        end
        run(63, 1, 99, 20, 1500, fin);
        chk("abort_no_finish", fin, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        chk("abort_row_count", row_count, 0);
        chk("abort_err", err, 0);
        rst = 1;
        run(63, 1, 99, -1, 1500, fin);
        chk("restart_finished", fin, 1);
        if (fin) finish_chk(64, 0);
        rd_all();
        run(99, 1, 5, -1, 1300, fin);
`ifdef PERM_STREAM_TIMEOUT_EN
        chk("timeout_finished", fin, 1);
        if (fin) finish_chk(5, 1);
`else
        chk("stall_no_finish", fin, 0);
        chk("stall_still_busy", busy, 1);
        @(negedge clk); rst = 0;
        @(negedge clk); rst = 1;
`endif
        for (int r = 0; r < 6; r++) begin
            load(1);
            co  = $urandom_range(0, 80);
            per = $urandom_range(1, 4);
            run(co, per, 99, -1, 1500, fin);
            chk("rand_finished", fin, 1);
            if (fin) finish_chk(co < 64 ? co + 1 : 64, co > 63);
            rd_all();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/perm_stream_master.md
PERM_STREAM_MASTER -- requirements
Module: perm_stream_master

Interface
REQ-001 The module SHALL have parameter WIDTH, default 25, row width in bits (one 5x5 slice).
REQ-002 The module SHALL have parameter ROWS, default 64, rows per state.
REQ-003 The module SHALL have parameter START_CYCLES, default 2, width of the core_start pulse in cycles.
REQ-004 The module SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have ports wr_en/wr_addr/wr_data  input  1/6/WIDTH  host write into the source buffer.
REQ-007 The module SHALL have ports rd_addr/rd_data  input/output  6/WIDTH  host read of the result buffer, registered.
REQ-008 The module SHALL have ports go/busy/done  input/output/output  1/1/1  run request, run in progress, one-cycle completion pulse.
REQ-009 The module SHALL have port row_count  output  7  rows exchanged in the last run.
REQ-010 The module SHALL have ports core_start/core_in  output  1/WIDTH  drive to the permutation core.
REQ-011 The module SHALL have ports core_ready/core_co/core_out  input  1/1/WIDTH  response from the permutation core.
REQ-012 The module SHALL have port err  output  1  sticky error flag, cleared by go.

Function
REQ-013 FSM states SHALL be IDLE, START, STREAM, FINISH.
REQ-014 IDLE -> START SHALL occur on go=1; go while busy=1 SHALL be ignored.
REQ-015 START SHALL hold core_start=1 for exactly START_CYCLES cycles, index i=0, then enter STREAM.
REQ-016 In STREAM, core_in SHALL equal source[i] combinationally from the registered index.
REQ-017 On each STREAM cycle with core_ready=1, core_out SHALL be written to result[i] and i SHALL increment.
REQ-018 STREAM -> FINISH SHALL occur on the accept cycle where core_co=1 or i=ROWS-1.
REQ-019 If i=ROWS-1 is accepted with core_co=0, err SHALL be set.
REQ-020 If core_co=1 arrives before i=ROWS-1, the run SHALL end early with err unchanged.
REQ-021 FINISH SHALL pulse done=1 for one cycle, load row_count=i+1, then return to IDLE.
REQ-022 busy SHALL be 1 in START, STREAM and FINISH.
REQ-023 Host writes while busy=1 SHALL be dropped; host reads SHALL be allowed at all times with 1-cycle latency.
REQ-024 Index arithmetic SHALL be 7-bit unsigned with no wrap past ROWS-1.

Reset
REQ-025 Reset assertion SHALL force IDLE asynchronously, even mid-run.
REQ-026 Reset values SHALL be busy=0, done=0, core_start=0, err=0, row_count=0, rd_data=0, i=0.
REQ-027 Buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With PERM_STREAM_TIMEOUT_EN defined, a 10-bit watchdog SHALL count STREAM cycles without core_ready, reset on each accept.
REQ-029 When the watchdog reaches 1023, err SHALL set, and the FSM SHALL go to FINISH with row_count=i.
REQ-030 Without PERM_STREAM_TIMEOUT_EN, STREAM SHALL wait for core_ready indefinitely and no watchdog logic SHALL exist.

Structure
REQ-031 Package perm_pkg SHALL hold WIDTH/ROWS defaults and the FSM state typedef.
REQ-032 Sub-module perm_row_buffer (1 write port, 1 registered read port, ROWS x WIDTH) SHALL be instantiated twice: source and result.

Verification
REQ-033 Load source[k]=k, go, core_ready=1 every cycle, core_co on row 63 -> core_start high 2 cycles, result[k]=core_out[k], done pulse, row_count=64, err=0.
REQ-034 core_ready asserted every 3rd cycle -> same result contents, and core_in stable between accepts.
REQ-035 core_co=1 at row 9 -> done after 10 rows, row_count=10, result[10..63] unchanged, err=0.
REQ-036 core_co never asserted -> row_count=64, err=1; next go clears err.
REQ-037 rst low during row 20 -> busy=0 within the same cycle, no done pulse; a new go restarts at row 0.
REQ-038 With PERM_STREAM_TIMEOUT_EN defined, core_ready stuck at 0 after row 5 -> err=1 and done pulse after 1023 idle cycles, row_count=5; without the macro -> busy stays 1.
